// File: rtl/token_encoder.sv
// Streaming word-to-token encoder: buffers a zero-delimited word, scans the vocabulary
// one entry per cycle and emits the lowest matching index. Optional: TOKEN_ENCODER_CASE_FOLD_EN.
module token_encoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_LEN     = 8,
  parameter int VOCAB_DEPTH = 16,
  parameter int ID_WIDTH    = $clog2(VOCAB_DEPTH),
  parameter int LEN_WIDTH   = $clog2(MAX_LEN + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                vocab_we,
  input  logic [ID_WIDTH+$clog2(MAX_LEN)-1:0] vocab_addr,
  input  logic [DATA_WIDTH-1:0]               vocab_din,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ID_WIDTH-1:0]                 out_id,
  output logic                                out_found,
  output logic [LEN_WIDTH-1:0]                out_len,
  output logic                                out_trunc,
  output logic                                busy
);
  localparam int POS_W = $clog2(MAX_LEN);

  typedef enum logic [1:0] {COLLECT, SEARCH, EMIT} state_e;

  state_e                state_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  trunc_q;
  logic [ID_WIDTH-1:0]   idx_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  found_q;
  logic [DATA_WIDTH-1:0] buffer_q [MAX_LEN];
  logic [DATA_WIDTH-1:0] vocab_q  [VOCAB_DEPTH][MAX_LEN];

  logic                  entry_hit;
  logic                  vocab_wr_en;
  logic [ID_WIDTH-1:0]   wr_entry;
  logic [POS_W-1:0]      wr_pos;
  logic [DATA_WIDTH-1:0] char_d;

  function automatic logic [DATA_WIDTH-1:0] fold_char(input logic [DATA_WIDTH-1:0] c);
`ifdef TOKEN_ENCODER_CASE_FOLD_EN
    if (c >= DATA_WIDTH'(8'h41) && c <= DATA_WIDTH'(8'h5A)) return c | DATA_WIDTH'(8'h20);
`endif
    return c;
  endfunction

  assign in_ready  = (state_q == COLLECT);
  assign busy      = (state_q != COLLECT);
  assign out_valid = (state_q == EMIT);
  assign out_id    = id_q;
  assign out_found = found_q;
  assign out_len   = len_q;
  assign out_trunc = trunc_q;

  assign char_d      = fold_char(in_data);
  assign wr_entry    = vocab_addr[ID_WIDTH+POS_W-1:POS_W];
  assign wr_pos      = vocab_addr[POS_W-1:0];
  // The table only changes between words, so a scan always sees a frozen vocabulary.
  assign vocab_wr_en = vocab_we && (state_q == COLLECT) && (len_q == '0);

  // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    entry_hit = 1'b1;
    for (int p = 0; p < MAX_LEN; p++) begin
      if (vocab_q[idx_q][p] != buffer_q[p]) entry_hit = 1'b0;
    end
  end

  // NOTE: the vocabulary is a register array that must read as zero after reset, so it is reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < VOCAB_DEPTH; e++) begin
        for (int p = 0; p < MAX_LEN; p++) vocab_q[e][p] <= '0;
      end
    end else if (vocab_wr_en) begin
      vocab_q[wr_entry][wr_pos] <= vocab_din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      len_q   <= '0;
      trunc_q <= 1'b0;
      idx_q   <= '0;
      id_q    <= '0;
      found_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) buffer_q[i] <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            if (in_data != '0) begin
              if (len_q < LEN_WIDTH'(MAX_LEN)) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                  if (LEN_WIDTH'(i) == len_q) buffer_q[i] <= char_d;
                end
                len_q <= len_q + LEN_WIDTH'(1);
              end else begin
                trunc_q <= 1'b1;
              end
            end else if (len_q != '0) begin
              state_q <= SEARCH;
              idx_q   <= '0;
            end
          end
        end
        SEARCH: begin
          // A truncated word walks the whole table so miss latency is fixed.
          if (entry_hit && !trunc_q) begin
            found_q <= 1'b1;
            id_q    <= idx_q;
            state_q <= EMIT;
          end else if (idx_q == ID_WIDTH'(VOCAB_DEPTH - 1)) begin
            found_q <= 1'b0;
            id_q    <= '0;
            state_q <= EMIT;
          end else begin
            idx_q <= idx_q + ID_WIDTH'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_q <= COLLECT;
            len_q   <= '0;
            trunc_q <= 1'b0;
            id_q    <= '0;
            found_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) buffer_q[i] <= '0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_token_encoder.sv
// Self-checking bench for token_encoder: a word-level reference model checks every cycle,
// directed cases pin hand-computed tokens, then a randomized stream runs against the model.
module tb_token_encoder;
  localparam int DW = 8;
  localparam int ML = 8;
  localparam int VD = 16;
  localparam int IW = $clog2(VD);
  localparam int LW = $clog2(ML + 1);
  localparam int AW = IW + $clog2(ML);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          vocab_we;
  logic [AW-1:0] vocab_addr;
  logic [DW-1:0] vocab_din;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_id;
  logic          out_found;
  logic [LW-1:0] out_len;
  logic          out_trunc;
  logic          busy;

  always #5 clk = ~clk;

  token_encoder #(.DATA_WIDTH(DW), .MAX_LEN(ML), .VOCAB_DEPTH(VD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .vocab_we(vocab_we), .vocab_addr(vocab_addr), .vocab_din(vocab_din),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_found(out_found), .out_len(out_len), .out_trunc(out_trunc), .busy(busy)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int tok_count = 0;
  int t_delim   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word-level view of the encoder.
  typedef enum {M_IDLE, M_PEND, M_VALID} mphase_e;
  mphase_e    ph = M_IDLE;
  logic [7:0] mv   [VD][ML];
  logic [7:0] wbuf [ML];
  int wlen = 0;
  int due = 0;
  int e_id = 0, e_found = 0, e_len = 0, e_trunc = 0;

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef TOKEN_ENCODER_CASE_FOLD_EN
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
`endif
    return c;
  endfunction

  function automatic void clear_word();
    wlen = 0;
    foreach (wbuf[p]) wbuf[p] = 8'h00;
  endfunction

  function automatic void model_reset();
    ph = M_IDLE;
    clear_word();
    foreach (mv[e, p]) mv[e][p] = 8'h00;
  endfunction

  function automatic void predict(input int t);
    int k = -1;
    if (wlen > ML) begin
      e_found = 0; e_id = 0; e_len = ML; e_trunc = 1; due = t + 1 + VD;
      return;
    end
    for (int e = 0; e < VD && k < 0; e++) begin
      bit eq;
      eq = 1'b1;
      for (int p = 0; p < ML; p++) if (mv[e][p] !== wbuf[p]) eq = 1'b0;
      if (eq) k = e;
    end
    e_len = wlen; e_trunc = 0;
    if (k >= 0) begin e_found = 1; e_id = k; due = t + 2 + k; end
    else begin e_found = 0; e_id = 0; due = t + 1 + VD; end
  endfunction

  // Compare process: at each falling edge, apply the inputs of the cycle just ended, then check this cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      model_reset();
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset out_id", out_id, 0);
      check("reset out_found", out_found, 0);
      check("reset out_len", out_len, 0);
      check("reset out_trunc", out_trunc, 0);
      check("reset busy", busy, 0);
    end else begin
      if (vocab_we && ph == M_IDLE && wlen == 0)
        mv[int'(vocab_addr) / ML][int'(vocab_addr) % ML] = vocab_din;
      if (ph == M_IDLE && in_valid) begin
        if (in_data != 8'h00) begin
          if (wlen < ML) wbuf[wlen] = fold(in_data);
          wlen++;
        end else if (wlen > 0) begin
          predict(cyc - 1);
          ph = M_PEND;
        end
      end else if (ph == M_VALID && out_ready) begin
        ph = M_IDLE;
        clear_word();
        tok_count++;
      end
      if (ph == M_PEND && cyc == due) ph = M_VALID;
      check("in_ready", in_ready, ph == M_IDLE);
      check("busy", busy, ph != M_IDLE);
      check("out_valid", out_valid, ph == M_VALID);
      if (ph == M_VALID) begin
        check("out_id", out_id, e_id);
        check("out_found", out_found, e_found);
        check("out_len", out_len, e_len);
        check("out_trunc", out_trunc, e_trunc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic vocab_write(input int entry, input int pos, input logic [7:0] c);
    vocab_we   = 1'b1;
    vocab_addr = AW'(entry * ML + pos);
    vocab_din  = c;
    step();
    vocab_we   = 1'b0;
  endtask

  task automatic load_word(input int entry, input string s);
    for (int p = 0; p < ML; p++) vocab_write(entry, p, (p < s.len()) ? s[p] : 8'h00);
  endtask

  task automatic send_char(input logic [7:0] c);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = c;
    for (int i = 0; i < 60 && !acc; i++) begin
      acc = in_ready;
      if (acc && c == 8'h00) t_delim = cyc;
      step();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    if (!acc) check("send_char timeout", 0, 1);
  endtask

  task automatic send_word(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    send_char(8'h00);
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      if (out_valid === 1'b1) begin
        lat = cyc - t_delim;
        break;
      end
      step();
    end
    if (lat < 0) check("out_valid timeout", 0, 1);
  endtask

  task automatic release_token();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic expect_token(input string name, input int id, input int found,
                              input int len, input int trunc, input int lat);
    int l;
    wait_valid(l);
    check({name, " latency"}, l, lat);
    check({name, " id"}, out_id, id);
    check({name, " found"}, out_found, found);
    check({name, " len"}, out_len, len);
    check({name, " trunc"}, out_trunc, trunc);
    release_token();
  endtask

  task automatic random_phase();
    logic [7:0] sq[$];
    logic [7:0] vch[4];
    string alpha;
    bit hold;
    bit acc;
    int guard;
    int n;
    vch   = '{8'h00, 8'h61, 8'h62, 8'h63};
    alpha = "abcA";
    hold  = 1'b0;
    guard = 0;
    load_word(1, "ab");
    load_word(4, "c");
    load_word(6, "abc");
    load_word(11, "ba");
    load_word(15, "cab");
    for (int w = 0; w < 120; w++) begin
      n = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 3) : $urandom_range(0, 11);
      for (int i = 0; i < n; i++) sq.push_back(alpha[$urandom_range(0, 3)]);
      sq.push_back(8'h00);
      if ($urandom_range(0, 9) == 0) sq.push_back(8'h00);
    end
    while (sq.size() > 0 && guard < 30000) begin
      guard++;
      if (!hold) in_valid = ($urandom_range(0, 3) != 0);
      in_data    = sq[0];
      out_ready  = ($urandom_range(0, 2) != 0);
      vocab_we   = ($urandom_range(0, 19) == 0);
      vocab_addr = AW'($urandom_range(0, VD * ML - 1));
      vocab_din  = vch[$urandom_range(0, 3)];
      acc = in_valid && in_ready;
      step();
      if (acc) void'(sq.pop_front());
      hold = in_valid && !acc;
    end
    in_valid  = 1'b0;
    vocab_we  = 1'b0;
    out_ready = 1'b1;
    repeat (40) step();
    out_ready = 1'b0;
    check("random stream drained", sq.size(), 0);
  endtask

  initial begin
    int l;
    int tok_before;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; vocab_we = 1'b0;
    vocab_addr = '0; vocab_din = '0; out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    load_word(3, "cat");
    send_word("cat");
    expect_token("match", 3, 1, 3, 0, 5);
    send_word("dog");
    expect_token("miss", 0, 0, 3, 0, 17);

    load_word(5, "ab");
    load_word(9, "ab");
    send_word("ab");
    expect_token("duplicate", 5, 1, 2, 0, 7);

    load_word(0, "abcdefgh");
    send_word("abcdefghij");
    expect_token("truncated", 0, 0, 8, 1, 17);
    send_word("abcdefgh");
    expect_token("full length", 0, 1, 8, 0, 2);

    send_word("cat");
    wait_valid(l);
    check("backpressure latency", l, 5);
    repeat (20) begin
      step();
      check("backpressure out_valid", out_valid, 1);
      check("backpressure in_ready", in_ready, 0);
      check("backpressure out_id", out_id, 3);
      check("backpressure out_len", out_len, 3);
    end
    release_token();

    tok_before = tok_count;
    out_ready = 1'b1;
    send_char(8'h63); send_char(8'h61); send_char(8'h74);
    send_char(8'h00); send_char(8'h00);
    repeat (25) step();
    out_ready = 1'b0;
    check("double delimiter tokens", tok_count - tok_before, 1);

    send_word("dog");
    vocab_write(7, 0, 8'h64);
    vocab_write(7, 1, 8'h6F);
    vocab_write(7, 2, 8'h67);
    expect_token("write during search", 0, 0, 3, 0, 17);
    send_word("dog");
    expect_token("write ignored", 0, 0, 3, 0, 17);

    send_word("cat");
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    send_word("cat");
    expect_token("after reset", 0, 0, 3, 0, 17);

`ifdef TOKEN_ENCODER_CASE_FOLD_EN
    load_word(2, "cat");
    send_word("CAT");
    expect_token("case fold", 2, 1, 3, 0, 4);
`endif

    random_phase();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/token_encoder.md
# token_encoder

Streaming word-to-token encoder for the tensor_core text front end. It is the parametrised successor of the fixed 16-entry encoder FSM. Characters arrive on a valid/ready stream and words are delimited by a zero character. Each word is buffered, matched against an internal loadable vocabulary table, and emitted as a token ID on a valid/ready output. Sits between the input-text SRAM reader and the embedding lookup.

## Interface
- DATA_WIDTH, 8: character width in bits.
- MAX_LEN, 8: maximum characters per word and per vocabulary entry.
- VOCAB_DEPTH, 16: number of vocabulary entries; power of two, ≥2.
- ID_WIDTH, $clog2(VOCAB_DEPTH): token ID width.
- LEN_WIDTH, $clog2(MAX_LEN+1): word length counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  character valid.
- in_ready  out  1  character accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  character; 0 = word delimiter.
- vocab_we  in  1  vocabulary write strobe.
- vocab_addr  in  ID_WIDTH+$clog2(MAX_LEN)  {entry, char position}.
- vocab_din  in  DATA_WIDTH  vocabulary character; unused positions = 0.
- out_valid  out  1  token valid.
- out_ready  in  1  token consumed when out_valid && out_ready.
- out_id  out  ID_WIDTH  matched entry index; 0 when not found.
- out_found  out  1  word matched an entry.
- out_len  out  LEN_WIDTH  buffered word length, saturating at MAX_LEN.
- out_trunc  out  1  word exceeded MAX_LEN.
- busy  out  1  high in SEARCH or EMIT.

## Operation
- The design has three states, COLLECT, SEARCH and EMIT; reset enters COLLECT.
- COLLECT:
  - in_ready=1.
  - A non-zero accepted char is stored at buffer[len] while len<MAX_LEN, and len increments.
  - When len==MAX_LEN, further chars are consumed and discarded, and trunc is set.
  - An accepted zero with len==0 is consumed and ignored; no token is produced and the state stays COLLECT.
  - An accepted zero with len>0 moves to SEARCH with idx=0.
- SEARCH:
  - in_ready=0. One entry is compared per cycle.
  - A match requires all MAX_LEN positions of entry[idx] to equal the zero-padded buffer.
  - On a match with trunc=0: found=1, id=idx, go to EMIT.
  - If no match and idx==VOCAB_DEPTH-1: found=0, id=0, go to EMIT. Otherwise idx increments.
  - The lowest matching index wins.
  - A truncated word never matches: found=0 and the full scan still runs, which keeps latency deterministic.
- EMIT:
  - out_valid=1; out_id, out_found, out_len and out_trunc are held stable.
  - On out_ready, go to COLLECT next cycle with len=0, trunc=0, and the buffer cleared.
- Vocabulary writes:
  - Writes take effect only in COLLECT with len==0; vocab_we is ignored otherwise.
  - An all-zero entry never matches a non-empty word.
- Reset mid-operation aborts any word or token. Buffer and vocabulary are cleared to 0.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_id=0, out_found=0, out_len=0, out_trunc=0, busy=0.
  - All vocabulary entries are 0.
- Delimiter accepted at cycle T:
  - busy=1 from T+1.
  - A match at entry k gives out_valid at T+2+k.
  - No match or a truncated word gives out_valid at T+1+VOCAB_DEPTH.
- Token handshake at cycle H: out_valid=0 and in_ready=1 from H+1.
- Back-to-back throughput is one word per (len+1)+(k+1)+1 cycles minimum.
- The vocabulary write is registered; the entry is visible to a delimiter accepted the following cycle.
- in_ready is a combinational function of state only; it has no path from in_valid or out_ready.

## Configuration
- TOKEN_ENCODER_CASE_FOLD_EN
  - Defined: characters 0x41–0x5A are mapped to 0x61–0x7A when stored into the buffer, giving case-insensitive matching. Vocabulary is stored as written and must be lowercase. Requires DATA_WIDTH≥7.
  - Undefined: characters are stored unchanged and matching is exact.

## Test plan
- Basic match:
  - Load entry 3 = "cat" (0x63,0x61,0x74, rest 0), other entries 0.
  - Stream 'c','a','t',0x00 continuously.
  - Expect out_valid 5 cycles after the delimiter; out_id=3, out_found=1, out_len=3, out_trunc=0.
- Miss:
  - Stream "dog",0 with entry 3 = "cat".
  - Expect out_valid at T+17 (VOCAB_DEPTH=16); out_found=0, out_id=0.
- Duplicate entries:
  - Entries 5 and 9 = "ab"; stream "ab",0.
  - Expect out_id=5.
- Truncation:
  - Stream 10 chars "abcdefghij",0 with entry 0 = "abcdefgh".
  - Expect out_found=0, out_len=8, out_trunc=1.
- Backpressure, empty words and protection:
  - Hold out_ready=0 for 20 cycles; outputs stay stable and in_ready=0.
  - A double delimiter emits exactly one token.
  - vocab_we during SEARCH leaves the table unchanged.
- Reset abort and case fold:
  - Assert rst during SEARCH: all outputs return to reset values and "cat" no longer matches.
  - With TOKEN_ENCODER_CASE_FOLD_EN defined, "CAT",0 matches entry "cat" with out_found=1.
